ifmap_spad_ctrl: RTL and testbench

PE-side controller that owns the single port of the 12x16-bit negedge ifmap scratch pad. It accepts ifmap words from the NoC/GLB over a valid/ready input and writes them into the spad as a circular row buffer. It reads the spad back as stride-1 sliding windows of FILT_W words and streams them to the PE MAC over a valid/ready output. It is the writer/reader counterpart of the spad's addr/we/data_in/data_out interface.

---
 rtl/ifmap_pkg.sv | 22 ++
 rtl/ifmap_spad_ctrl_ring_ptr.sv | 30 +++
 rtl/ifmap_spad_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_ifmap_spad_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifmap_pkg.sv
// ifmap spad controller shared types: state encoding and spad geometry.
package ifmap_pkg;

  localparam int DATA_W      = 16;
  localparam int SPAD_DEPTH  = 12;
  localparam int SPAD_ADDR_W = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FILL    = 3'd1;
  localparam logic [2:0] ST_READ    = 3'd2;
  localparam logic [2:0] ST_ADVANCE = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    FILL    = ST_FILL,
    READ    = ST_READ,
    ADVANCE = ST_ADVANCE,
    DRAIN   = ST_DRAIN
  } state_e;

endpackage

// File: rtl/ifmap_spad_ctrl_ring_ptr.sv
// Modulo-N ring pointer with clear/load/inc.
// clear wins over load, load wins over inc.
module ring_ptr #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] val
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      val <= '0;
    end else if (clear) begin
      val <= '0;
    end else if (load) begin
      val <= load_val;
    end else if (inc) begin
      val <= (val == LAST) ? '0 : val + 1'b1;
    end
  end

endmodule

// File: rtl/ifmap_spad_ctrl.sv
// ifmap spad controller: circular row fill, sliding-window readout.
// IFMAP_CTRL_PERF_EN adds saturating input/output stall counters.
module ifmap_spad_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = ifmap_pkg::SPAD_ADDR_W,
  parameter int DEPTH  = ifmap_pkg::SPAD_DEPTH,
  parameter int FILT_W = 3,
  parameter int NWIN_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NWIN_W-1:0] num_windows,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
`ifdef IFMAP_CTRL_PERF_EN
  output logic [15:0]       stall_in_cnt,
  output logic [15:0]       stall_out_cnt,
`endif
  output logic [ADDR_W-1:0] spad_addr,
  output logic              spad_we,
  output logic [DATA_W-1:0] spad_wdata,
  input  logic [DATA_W-1:0] spad_rdata
);

  import ifmap_pkg::*;

  localparam int PW = (FILT_W > 1) ? $clog2(FILT_W) : 1;
  localparam logic [PW-1:0] LAST = PW'(FILT_W - 1);

  if (FILT_W > DEPTH || PW > ADDR_W) begin : g_cfg_err
    $error("ifmap_spad_ctrl: FILT_W does not fit the spad");
  end

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    return (v == LAST) ? '0 : v + 1'b1;
  endfunction

  state_e            state;
  logic [NWIN_W-1:0] nwin;
  logic [NWIN_W-1:0] win_cnt;
  logic [NWIN_W-1:0] win_nxt;
  logic [PW-1:0]     elem;
  logic [PW-1:0]     base;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_load_val;

  logic wr_fire;
  logic out_fire;
  logic capture;
  logic accept;
  logic go;
  logic fill_done;
  logic adv_fire;
  logic rd_load;

  assign in_ready  = (state == FILL) || (state == ADVANCE);
  assign wr_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign capture   = (state == READ) && (!out_valid || out_ready);
  assign accept    = (state == IDLE) && start;
  assign go        = accept && (num_windows != '0);
  assign fill_done = (state == FILL) && wr_fire && (wr_ptr == LAST);
  assign adv_fire  = (state == ADVANCE) && wr_fire;
  assign win_nxt   = win_cnt + 1'b1;

  // ADVANCE reloads the reader at the slot just past the overwritten one
  assign rd_load     = fill_done || adv_fire;
  assign rd_load_val = adv_fire ? wrap_inc(base) : base;

  assign spad_we    = wr_fire;
  assign spad_wdata = in_data;
  assign spad_addr  = ADDR_W'((state == READ) ? rd_ptr : wr_ptr);
  assign busy       = (state != IDLE);

  ring_ptr #(.N(FILT_W), .W(PW)) u_base (
    .clk      (clk),
    .reset    (reset),
    .clear    (go),
    .load     (1'b0),
    .load_val ('0),
    .inc      (adv_fire),
    .val      (base)
  );

  ring_ptr #(.N(FILT_W), .W(PW)) u_wr (
    .clk      (clk),
    .reset    (reset),
    .clear    (go),
    .load     (1'b0),
    .load_val ('0),
    .inc      (wr_fire),
    .val      (wr_ptr)
  );

  ring_ptr #(.N(FILT_W), .W(PW)) u_rd (
    .clk      (clk),
    .reset    (reset),
    .clear    (1'b0),
    .load     (rd_load),
    .load_val (rd_load_val),
    .inc      (capture),
    .val      (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      nwin      <= '0;
      win_cnt   <= '0;
      elem      <= '0;
    end else begin
      done <= 1'b0;
      if (capture) begin
        out_data  <= spad_rdata;
        out_valid <= 1'b1;
        out_last  <= (elem == LAST);
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            if (num_windows == '0) begin
              done <= 1'b1;
            end else begin
              nwin    <= num_windows;
              win_cnt <= '0;
              state   <= FILL;
            end
          end
        end
        FILL: begin
          if (fill_done) begin
            elem  <= '0;
            state <= READ;
          end
        end
        READ: begin
          if (capture) begin
            if (elem == LAST) begin
              elem    <= '0;
              win_cnt <= win_nxt;
              state   <= (win_nxt == nwin) ? DRAIN : ADVANCE;
            end else begin
              elem <= elem + 1'b1;
            end
          end
        end
        ADVANCE: begin
          if (wr_fire) begin
            elem  <= '0;
            state <= READ;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IFMAP_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      stall_in_cnt  <= '0;
      stall_out_cnt <= '0;
    end else begin
      if (in_ready && !in_valid && stall_in_cnt != 16'hFFFF) begin
        stall_in_cnt <= stall_in_cnt + 16'd1;
      end
      if (out_valid && !out_ready && stall_out_cnt != 16'hFFFF) begin
        stall_out_cnt <= stall_out_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifmap_spad_ctrl.sv
// Bench for ifmap_spad_ctrl: window scoreboard, negedge spad model,
// vector table plus zero-window, mid-run reset and perf sequences.
module tb_ifmap_spad_ctrl;

  localparam int FW = 3;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [NW-1:0] num_windows;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [AW-1:0] spad_addr;
  logic          spad_we;
  logic [DW-1:0] spad_wdata;
  logic [DW-1:0] spad_rdata;
`ifdef IFMAP_CTRL_PERF_EN
  logic [15:0]   stall_in_cnt;
  logic [15:0]   stall_out_cnt;
`endif

  always #5 clk = ~clk;

  ifmap_spad_ctrl #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (12),
    .FILT_W (FW),
    .NWIN_W (NW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_windows   (num_windows),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done),
`ifdef IFMAP_CTRL_PERF_EN
    .stall_in_cnt  (stall_in_cnt),
    .stall_out_cnt (stall_out_cnt),
`endif
    .spad_addr     (spad_addr),
    .spad_we       (spad_we),
    .spad_wdata    (spad_wdata),
    .spad_rdata    (spad_rdata)
  );

  // negedge single-port spad
  logic [DW-1:0] mem [0:15];
  always @(negedge clk) begin
    if (spad_we) mem[spad_addr] <= spad_wdata;
    spad_rdata <= spad_we ? spad_wdata : mem[spad_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  typedef struct {
    int nw;
    int rmode;
    int gmode;
    bit rnd;
    int exp_elems;
    int exp_writes;
  } vec_t;

  exp_t          exp_q[$];
  logic [DW-1:0] wq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  // rmode: 0 ready, 1 pattern 1001, 2 random, 3 exactly 5 stalls
  // gmode: 0 no gaps + junk after last word, 1 random gaps, 3 exactly 2 gaps
  task automatic run_row(input int nw, input int rmode, input int gmode,
                         input int exp_elems, input int exp_writes,
                         input int abort_at);
    int   widx, elems, writes, dones, last_fire, post;
    int   in_left, out_left;
    bit   vld, prev_stall, prev_ir;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr;
    exp_t e;
    exp_q.delete();
    for (int k = 0; k < nw; k++)
      for (int j = 0; j < FW; j++)
        exp_q.push_back('{wq[k+j], (j == FW - 1)});
    widx = 0; elems = 0; writes = 0; dones = 0;
    last_fire = -10; post = 0; in_left = 2; out_left = 5;
    vld = 0; prev_stall = 0; prev_ir = 0;
    prev_data = '0; prev_addr = '0;
    @(posedge clk); #1;
    start = 1; num_windows = NW'(nw); in_valid = 0; out_ready = 1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      start = 0;
      if (!vld && widx < wq.size()) begin
        if (gmode == 1 && $urandom_range(2) == 0) vld = 0;
        else if (gmode == 3 && in_ready && in_left > 0) in_left--;
        else vld = 1;
      end
      in_valid = vld || (gmode == 0 && widx >= wq.size());
      in_data  = (widx < wq.size()) ? wq[widx] : 16'hDEAD;
      if (rmode == 0) out_ready = 1;
      else if (rmode == 1) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      else if (rmode == 2) out_ready = 1'($urandom_range(1));
      else begin
        out_ready = !(out_valid && out_left > 0);
        if (!out_ready) out_left--;
      end
      @(negedge clk);
      chk("spad_we", spad_we, in_valid && in_ready);
      if (spad_we) begin
        writes++;
        if (widx < wq.size()) begin
          chk("wr_addr", spad_addr, widx % FW);
          chk("wr_data", spad_wdata, wq[widx]);
        end else flag("extra_write");
      end
      if (in_valid && in_ready && vld) begin
        widx++;
        vld = 0;
      end
      if (prev_stall && !prev_ir) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_addr", spad_addr, prev_addr);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) flag("extra_output");
        else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_last", out_last, e.l);
        end
        elems++;
        last_fire = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_ir    = in_ready;
      prev_data  = out_data;
      prev_addr  = spad_addr;
      if (done) begin
        dones++;
        chk("done_after_fire", cyc - last_fire, 1);
        chk("done_busy", busy, 0);
      end
      if (abort_at > 0 && elems >= abort_at) break;
      if (dones > 0) post++;
      if (post >= 3) break;
    end
    if (abort_at == 0) begin
      if (dones == 0) flag("timeout_no_done");
      chk("elems", elems, exp_elems);
      chk("writes", writes, exp_writes);
      chk("done_count", dones, 1);
    end
    in_valid = 0;
  endtask

  vec_t vt[6];

  initial begin
    vt[0] = '{3, 0, 0, 0, 9, 5};
    vt[1] = '{3, 1, 0, 0, 9, 5};
    vt[2] = '{3, 0, 1, 0, 9, 5};
    vt[3] = '{5, 2, 1, 1, 15, 7};
    vt[4] = '{1, 0, 0, 1, 3, 3};
    vt[5] = '{4, 2, 0, 1, 12, 6};

    for (int i = 0; i < 16; i++) mem[i] = '0;
    reset = 1; start = 0; num_windows = '0;
    in_data = '0; in_valid = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_spad_we", spad_we, 0);

    for (int v = 0; v < 6; v++) begin
      wq.delete();
      for (int i = 0; i < vt[v].nw + FW - 1; i++)
        wq.push_back(vt[v].rnd ? DW'($urandom_range(65535)) : DW'(10 * (i + 1)));
      run_row(vt[v].nw, vt[v].rmode, vt[v].gmode,
              vt[v].exp_elems, vt[v].exp_writes, 0);
    end

    // zero windows: done next cycle, nothing else moves
    @(posedge clk); #1;
    start = 1; num_windows = '0; in_valid = 1; out_ready = 1;
    @(negedge clk);
    chk("zw_done_early", done, 0);
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("zw_done", done, 1);
    chk("zw_in_ready", in_ready, 0);
    chk("zw_spad_we", spad_we, 0);
    chk("zw_out_valid", out_valid, 0);
    chk("zw_busy", busy, 0);
    @(negedge clk);
    chk("zw_done_once", done, 0);
    in_valid = 0;

    // reset in the middle of window 2, then a clean refill
    wq.delete();
    for (int i = 0; i < 5; i++) wq.push_back(DW'(10 * (i + 1)));
    run_row(3, 0, 0, 0, 0, 4);
    @(posedge clk); #1;
    reset = 1; in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    repeat (3) begin
      @(negedge clk);
      chk("mr_no_done", done, 0);
    end
    wq.delete();
    for (int i = 1; i <= 3; i++) wq.push_back(DW'(i));
    run_row(1, 0, 0, 3, 3, 0);

`ifdef IFMAP_CTRL_PERF_EN
    wq.delete();
    for (int i = 7; i <= 9; i++) wq.push_back(DW'(i));
    run_row(1, 3, 3, 3, 3, 0);
    chk("perf_out", stall_out_cnt, 5);
    chk("perf_in", stall_in_cnt, 2);
    @(posedge clk); #1;
    start = 1; num_windows = 8'd1;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("perf_out_clr", stall_out_cnt, 0);
    chk("perf_in_clr", stall_in_cnt, 0);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
